// File: rtl/corescore_uart_bridge_pkg.sv
// Shared types and constants for the CoreScore UART bridge.
// The TAG arbiter state exists only when CORESCORE_UART_BRIDGE_TAG_EN is defined.
package corescore_uart_bridge_pkg;

    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] TAG_BASE = 8'h30;

`ifdef CORESCORE_UART_BRIDGE_TAG_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TAG   = 2'd2
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } arb_state_e;
`endif

    // ASCII tag character announcing the channel that owns the next packet
    function automatic logic [CHAR_W-1:0] tag_char(input logic [2:0] ch);
        return TAG_BASE + {5'd0, ch};
    endfunction

endpackage

// File: rtl/corescore_uart_bridge_fifo.sv
// Synchronous character FIFO with registered occupancy count.
// Full/empty come from the registered count, so a same-cycle pop never
// frees room for a push into a full FIFO.
module corescore_uart_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == (AW+1)'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign level     = count_r;

    // Storage array: written on every accepted push, never reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks push minus pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/corescore_uart_bridge.sv
// CoreScore UART bridge: packet-atomic round-robin merge of NCH byte
// streams into a character FIFO that drains into a JTAG-UART style sink.
// Optional feature macro: CORESCORE_UART_BRIDGE_TAG_EN (prefixes every
// packet with the ASCII channel tag '0'+channel).
module corescore_uart_bridge
    import corescore_uart_bridge_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NCH*8-1:0]       i_tdata,
    input  logic [NCH-1:0]         i_tlast,
    input  logic [NCH-1:0]         i_tvalid,
    output logic [NCH-1:0]         o_tready,
    input  logic                   i_sink_ena,
    output logic [CHAR_W-1:0]      o_sink_dat,
    output logic                   o_sink_val,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CH_W-1:0] GRANT_RST = CH_W'(NCH - 1);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic [CH_W-1:0]     grant_r;
    logic [CH_W-1:0]     grant_s;
    logic [CH_W-1:0]     rr_sel_s;
    logic                rr_hit_s;
    logic [NCH-1:0]      tready_s;
    logic                fifo_push_s;
    logic [CHAR_W-1:0]   fifo_wdata_s;
    logic                fifo_pop_s;
    logic [CHAR_W-1:0]   fifo_rdata_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    // Round-robin pick: first valid channel after the last granted one
    always_comb begin : rr_pick
        int idx;
        idx      = 0;
        rr_sel_s = grant_r;
        rr_hit_s = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(grant_r) + k) % NCH;
            if (!rr_hit_s && i_tvalid[idx]) begin
                rr_sel_s = CH_W'(idx);
                rr_hit_s = 1'b1;
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
    end

    // Arbiter next state, ready generation and FIFO write port
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        tready_s     = '0;
        fifo_push_s  = 1'b0;
        fifo_wdata_s = 8'h00;
        case (state_r)
            IDLE: begin
                if (rr_hit_s) begin
                    grant_s = rr_sel_s;
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
                    state_s = TAG;
`else
                    state_s = GRANT;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
            TAG: begin
                if (!fifo_full_s) begin
                    fifo_push_s  = 1'b1;
                    fifo_wdata_s = tag_char(3'(grant_r));
                    state_s      = GRANT;
                end else begin
                    state_s = TAG;
                end
            end
`endif
            GRANT: begin
                tready_s[grant_r] = ~fifo_full_s;
                if (i_tvalid[grant_r] && !fifo_full_s) begin
                    fifo_push_s  = 1'b1;
                    fifo_wdata_s = i_tdata[{grant_r, 3'b000} +: CHAR_W];
                    if (i_tlast[grant_r]) begin
                        state_s = IDLE;
                    end else begin
                        state_s = GRANT;
                    end
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign o_tready   = tready_s;
    assign fifo_pop_s = ~fifo_empty_s & i_sink_ena;

    // Arbiter state and last-granted channel; reset makes channel 0 win first
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            grant_r <= GRANT_RST;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
        end
    end

    corescore_uart_bridge_fifo #(
        .DEPTH (DEPTH),
        .W     (CHAR_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (fifo_push_s),
        .wdata (fifo_wdata_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .level (o_level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sink stage: one-cycle strobe after each pop, data held between strobes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sink_val <= 1'b0;
            o_sink_dat <= 8'h00;
        end else begin
            o_sink_val <= fifo_pop_s;
            if (fifo_pop_s) begin
                o_sink_dat <= fifo_rdata_s;
            end
        end
    end

endmodule

// File: tb/tb_corescore_uart_bridge.sv
// Scoreboard bench for corescore_uart_bridge: packet-level reference model
// predicts channel order and byte stream; a monitor checks the sink output.
module tb_corescore_uart_bridge;

    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
    localparam int LAT       = 1;
    localparam int FULL_BEATS = DEPTH - 1;
`else
    localparam int LAT       = 2;
    localparam int FULL_BEATS = DEPTH;
`endif

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [NCH*8-1:0]   i_tdata;
    logic [NCH-1:0]     i_tlast;
    logic [NCH-1:0]     i_tvalid;
    logic [NCH-1:0]     o_tready;
    logic               i_sink_ena;
    logic [7:0]         o_sink_dat;
    logic               o_sink_val;
    logic [LW-1:0]      o_level;

    always #5 i_clk = ~i_clk;

    corescore_uart_bridge #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .o_tready   (o_tready),
        .i_sink_ena (i_sink_ena),
        .o_sink_dat (o_sink_dat),
        .o_sink_val (o_sink_val),
        .o_level    (o_level)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] chq [NCH][$];   // per-channel pending beats {last, data}
    logic [7:0] expq[$];        // expected sink characters in order
    logic [7:0] rxq[$];         // characters observed on the sink
    int  cur_ch, pred_ch, last_ch, acc_cnt;
    int  first_acc_cyc, first_val_cyc;
    bit  mon_en = 1'b0;
    bit  gap_en = 1'b0;
    bit  ena_rand = 1'b0;
    bit  ena_fixed = 1'b1;
    logic [7:0] exp_b;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: every strobe must match the head of the scoreboard
    always @(negedge i_clk) begin
        if (mon_en && o_sink_val) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            rxq.push_back(o_sink_dat);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL sink_unexpected got %02h expected nothing", o_sink_dat);
            end else begin
                exp_b = expq.pop_front();
                if (o_sink_dat !== exp_b) begin
                    errors++;
                    $display("FAIL sink_byte got %02h expected %02h", o_sink_dat, exp_b);
                end
            end
        end
    end

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) chq[c].delete();
        expq.delete();
        rxq.delete();
        cur_ch = -1; pred_ch = -1; last_ch = NCH - 1; acc_cnt = 0;
        first_acc_cyc = -1; first_val_cyc = -1;
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if (chq[c].size() > 0) begin
                i_tdata[c*8 +: 8] = chq[c][0][7:0];
                i_tlast[c]        = chq[c][0][8];
                i_tvalid[c]       = !(gap_en && cur_ch == c && $urandom_range(0, 3) == 0);
            end else begin
                i_tvalid[c]       = 1'b0;
                i_tdata[c*8 +: 8] = 8'($urandom);
                i_tlast[c]        = 1'($urandom_range(0, 1));
            end
        end
        i_sink_ena = ena_rand ? 1'($urandom_range(0, 1)) : ena_fixed;
    endtask

    // One clock: model the arbiter at packet level, record accepted beats
    task automatic step();
        logic [NCH-1:0] acc;
        @(negedge i_clk);
        if (cur_ch < 0 && pred_ch < 0 && i_tvalid != '0) begin
            for (int k = 1; k <= NCH; k++) begin
                if (pred_ch < 0 && i_tvalid[(last_ch + k) % NCH]) pred_ch = (last_ch + k) % NCH;
            end
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
            expq.push_back(8'h30 + 8'(pred_ch));
`endif
        end
        acc = i_tvalid & o_tready;
        if (acc != '0) begin
            checks++;
            if ($countones(acc) != 1) begin
                errors++;
                $display("FAIL multi_accept got %b expected one-hot", acc);
            end
            for (int c = 0; c < NCH; c++) begin
                if (acc[c]) begin
                    if (cur_ch < 0) begin
                        checks++;
                        if (c != pred_ch) begin
                            errors++;
                            $display("FAIL arb_order got ch%0d expected ch%0d", c, pred_ch);
                        end
                        cur_ch = c; pred_ch = -1;
                        if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    end else if (c != cur_ch) begin
                        errors++;
                        $display("FAIL interleave got ch%0d expected ch%0d", c, cur_ch);
                    end
                    expq.push_back(chq[c][0][7:0]);
                    acc_cnt++;
                    if (chq[c][0][8]) begin
                        last_ch = c; cur_ch = -1;
                    end
                end
            end
        end
        @(posedge i_clk); #1;
        for (int c = 0; c < NCH; c++) if (acc[c]) void'(chq[c].pop_front());
        drive();
    endtask

    // Hold reset with toggling inputs and check all outputs stay cleared
    task automatic do_reset(int ncyc);
        i_rst_n = 1'b0;
        mon_en  = 1'b0;
        clear_model();
        for (int i = 0; i < ncyc; i++) begin
            i_tvalid = NCH'($urandom); i_tdata = (NCH*8)'($urandom);
            i_tlast  = NCH'($urandom); i_sink_ena = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
            checks++;
            if (o_tready !== '0 || o_sink_val !== 1'b0 || o_sink_dat !== 8'h00 || o_level !== '0) begin
                errors++;
                $display("FAIL reset_outputs got rdy=%b val=%b dat=%02h lvl=%0d expected all 0",
                         o_tready, o_sink_val, o_sink_dat, o_level);
            end
        end
        i_tvalid = '0;
        i_rst_n  = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_sink_val !== 1'b0 || o_level !== '0) begin
            errors++;
            $display("FAIL post_reset got val=%b lvl=%0d expected 0/0", o_sink_val, o_level);
        end
        mon_en = 1'b1;
        drive();
    endtask

    function automatic bit busy();
        bit b = (expq.size() != 0) || (cur_ch >= 0) || (pred_ch >= 0);
        for (int c = 0; c < NCH; c++) if (chq[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (n >= budget || expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d bytes left expected 0", expq.size());
        end
    endtask

    task automatic load_str(int c, string s);
        for (int i = 0; i < s.len(); i++) chq[c].push_back({(i == s.len() - 1), s[i]});
    endtask

    task automatic cmp_rx(string name, logic [7:0] want[$]);
        checks++;
        if (rxq.size() != want.size()) begin
            errors++;
            $display("FAIL %s_len got %0d expected %0d", name, rxq.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                checks++;
                if (rxq[i] !== want[i]) begin
                    errors++;
                    $display("FAIL %s_seq[%0d] got %02h expected %02h", name, i, rxq[i], want[i]);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] want[$];
        int len;
        i_rst_n = 1'b0; i_tvalid = '0; i_tdata = '0; i_tlast = '0; i_sink_ena = 1'b0;

        // Reset with toggling inputs
        do_reset(6);

        // Single channel "Hi\n" with the sink always ready
        ena_rand = 1'b0; ena_fixed = 1'b1;
        load_str(0, "Hi\n");
        drive();
        drain(200);
        checks++;
        if (first_val_cyc - first_acc_cyc != LAT) begin
            errors++;
            $display("FAIL latency got %0d expected %0d", first_val_cyc - first_acc_cyc, LAT);
        end
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
        want = '{8'h30, 8'h48, 8'h69, 8'h0A};
`else
        want = '{8'h48, 8'h69, 8'h0A};
`endif
        cmp_rx("hi", want);

        // Round robin across two channels, two packets each
        do_reset(2);
        ena_rand = 1'b1;
        load_str(0, "AB"); load_str(0, "EF");
        load_str(1, "CD"); load_str(1, "GH");
        drive();
        drain(400);
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
        want = '{8'h30, "A", "B", 8'h31, "C", "D", 8'h30, "E", "F", 8'h31, "G", "H"};
`else
        want = '{"A", "B", "C", "D", "E", "F", "G", "H"};
`endif
        cmp_rx("rr", want);

        // Backpressure: sink blocked, 20 beats offered, FIFO fills to DEPTH
        do_reset(2);
        ena_rand = 1'b0; ena_fixed = 1'b0;
        for (int i = 0; i < 20; i++) chq[0].push_back({(i == 19), 8'($urandom)});
        drive();
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (o_level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_level got %0d expected %0d", o_level, DEPTH);
        end
        checks++;
        if (o_tready !== '0) begin
            errors++;
            $display("FAIL full_ready got %b expected 0", o_tready);
        end
        checks++;
        if (acc_cnt != FULL_BEATS) begin
            errors++;
            $display("FAIL full_beats got %0d expected %0d", acc_cnt, FULL_BEATS);
        end
        ena_fixed = 1'b1;
        drive();
        drain(400);

        // Reset after 3 of 8 beats, then a fresh packet must come through intact
        do_reset(2);
        ena_fixed = 1'b0;
        for (int i = 0; i < 8; i++) chq[0].push_back({(i == 7), 8'($urandom)});
        drive();
        for (int i = 0; i < 50 && acc_cnt < 3; i++) step();
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL midpkt_beats got %0d expected 3", acc_cnt);
        end
        do_reset(2);
        ena_fixed = 1'b1;
        load_str(0, "wxyz");
        drive();
        drain(200);
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
        want = '{8'h30, "w", "x", "y", "z"};
`else
        want = '{"w", "x", "y", "z"};
`endif
        cmp_rx("midpkt", want);

        // Tag behaviour: channel 1 sends "x"
        do_reset(2);
        load_str(1, "x");
        drive();
        drain(200);
`ifdef CORESCORE_UART_BRIDGE_TAG_EN
        want = '{8'h31, 8'h78};
`else
        want = '{8'h78};
`endif
        cmp_rx("tag", want);

        // Random traffic: random packets, mid-packet gaps, random sink readiness
        do_reset(2);
        ena_rand = 1'b1; gap_en = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) chq[c].push_back({(i == len - 1), 8'($urandom)});
            end
        end
        drive();
        drain(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
